// File: rtl/usb_buf_sched.sv
// usb_buf_sched: ownership of the 4-region USB TX buffer; define HS_PRIORITY_EN to serve region 0 first.
// Latency: wr_eop -> full_map +1 cycle, -> rd_start +2 cycles; rd_done -> next rd_start +2 cycles.
// Backpressure: rd_rdy low parks reads in IDLE; writes to a still-full region are dropped and counted.
module usb_buf_sched #(
    parameter int BADDR_NBIT   = 2,
    parameter int OVF_CNT_NBIT = 16
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic                         wr_eop,
    input  logic [BADDR_NBIT-1:0]        wr_baddr,
    output logic [BADDR_NBIT-1:0]        free_baddr,
    output logic                         free_vd,
    output logic                         acq_throttle,
    input  logic                         rd_rdy,
    output logic                         rd_start,
    output logic [BADDR_NBIT-1:0]        rd_baddr,
    input  logic                         rd_done,
    output logic [(2**BADDR_NBIT)-1:0]   full_map,
    output logic [OVF_CNT_NBIT-1:0]      ovf_cnt
);

    localparam int NREG = 2**BADDR_NBIT;

    typedef logic [BADDR_NBIT-1:0] baddr_t;
    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t              state, state_nxt;
    baddr_t              q_mem [NREG];
    baddr_t              q_wr, q_rd;
    logic [BADDR_NBIT:0] q_cnt;
    logic                q_push, q_pop, q_empty;
    baddr_t              last_data;
    baddr_t              rd_sel;
    logic                rd_load, rd_release;
    logic                wr_hit, wr_ok, wr_ovf;
    logic [NREG-1:0]     rel_mask, full_eff, wr_mask;
    logic                hs_pend;

    // Data regions rotate 1..NREG-1; region 0 (handshake) maps back into the rotation at 1.
    function automatic baddr_t rot_next(input baddr_t b);
        if (b == '0 || b == '1)
            return baddr_t'(1);
        return b + baddr_t'(1);
    endfunction

    // A release in the same cycle as a write to that region lands first, so the write is accepted.
    assign rd_release = (state == BUSY) && rd_done;
    assign rel_mask   = rd_release ? (NREG'(1) << rd_baddr) : '0;
    assign full_eff   = full_map & ~rel_mask;
    assign wr_hit     = full_eff[wr_baddr];
    assign wr_ok      = wr_eop && !wr_hit;
    assign wr_ovf     = wr_eop && wr_hit;
    assign wr_mask    = wr_ok ? (NREG'(1) << wr_baddr) : '0;

    assign q_empty      = (q_cnt == '0);
    assign free_vd      = ~full_map[free_baddr];
    assign acq_throttle = ~free_vd;

`ifdef HS_PRIORITY_EN
    assign q_push = wr_ok && (wr_baddr != '0);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)
            hs_pend <= 1'b0;
        else
            hs_pend <= (hs_pend && !(rd_release && rd_baddr == '0)) ||
                       (wr_ok && wr_baddr == '0);
    end
`else
    assign q_push  = wr_ok;
    assign hs_pend = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        q_pop     = 1'b0;
        rd_load   = 1'b0;
        rd_start  = 1'b0;
        rd_sel    = q_mem[q_rd];
        case (state)
            IDLE: begin
                if (rd_rdy) begin
                    if (hs_pend) begin
                        rd_load   = 1'b1;
                        rd_sel    = '0;
                        state_nxt = START;
                    end else if (!q_empty) begin
                        rd_load   = 1'b1;
                        q_pop     = 1'b1;
                        state_nxt = START;
                    end
                end
            end
            START: begin
                rd_start  = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (rd_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_baddr   <= '0;
            full_map   <= '0;
            ovf_cnt    <= '0;
            last_data  <= '0;
            free_baddr <= baddr_t'(1);
        end else begin
            state <= state_nxt;
            if (rd_load)
                rd_baddr <= rd_sel;
            full_map <= full_eff | wr_mask;
            if (wr_ovf && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + OVF_CNT_NBIT'(1);
            if (wr_eop && wr_baddr != '0)
                last_data <= wr_baddr;
            free_baddr <= rot_next(last_data);
        end
    end

    // Completion-order queue; a region is never queued twice, so NREG entries cannot overflow.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
            for (int i = 0; i < NREG; i++)
                q_mem[i] <= '0;
        end else begin
            if (q_push) begin
                q_mem[q_wr] <= wr_baddr;
                q_wr        <= q_wr + baddr_t'(1);
            end
            if (q_pop)
                q_rd <= q_rd + baddr_t'(1);
            case ({q_push, q_pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

endmodule

// File: doc/usb_buf_sched.md
Name: usb_buf_sched

Overview:
- Schedules ownership of the 4-region USB TX buffer between the command/ADC frame writer and the USB endpoint reader.
- Region 0 holds the handshake reply; regions 1..3 hold ADC data frames and rotate 1→2→3→1.
- Marks regions full on writer end-of-packet and queues them for readout in completion order.
- Issues one read start at a time, frees each region on read done, and tells the writer whether its next rotation region is free.

Parameters:
- BADDR_NBIT, 2, buffer base-address width; number of regions is NREG = 2**BADDR_NBIT.
- OVF_CNT_NBIT, 16, width of the saturating overflow counter.

Ports:
- mclk  input  1  main clock, 48 MHz.
- rst_n  input  1  asynchronous active-low reset.
- wr_eop  input  1  one-cycle pulse: writer finished filling region wr_baddr.
- wr_baddr  input  BADDR_NBIT  region just written; sampled with wr_eop.
- free_baddr  output  BADDR_NBIT  next data region in the writer rotation.
- free_vd  output  1  free_baddr region is empty.
- acq_throttle  output  1  equals ~free_vd; writer must skip the next ADC frame.
- rd_rdy  input  1  USB endpoint can accept a packet.
- rd_start  output  1  one-cycle pulse: read region rd_baddr.
- rd_baddr  output  BADDR_NBIT  region being read; held stable until rd_done.
- rd_done  input  1  one-cycle pulse: reader finished region rd_baddr.
- full_map  output  NREG  per-region full flags.
- ovf_cnt  output  OVF_CNT_NBIT  count of dropped writes, saturating.

Behaviour:
- Reset values of all outputs/state: full_map=0, ovf_cnt=0, rd_start=0, rd_baddr=0, last_data=0, free_baddr=1, free_vd=1, queue empty, read FSM in IDLE.
- Reset mid-transfer abandons the transfer: all regions free, queue empty.
- Write side, on wr_eop:
  - If full_map[wr_baddr]=1: the write is an overflow. ovf_cnt increments, saturating at all-ones; the queue and full_map are unchanged.
  - Otherwise full_map[wr_baddr] is set the next cycle and wr_baddr is pushed to the completion queue.
  - If wr_baddr≠0, last_data updates to wr_baddr.
- free_baddr is registered: next(last_data), where next(0)=1, next(3)=1, otherwise +1.
- free_vd = ~full_map[free_baddr], combinational from registers.
- Completion queue:
  - Depth NREG, entries BADDR_NBIT wide.
  - It cannot overflow, because a region is never queued twice.
  - A push and a pop in the same cycle are both honoured.
- Read FSM states IDLE, START, BUSY:
  - IDLE: if rd_rdy and a candidate exists, pop it, latch rd_baddr and go to START.
  - START: rd_start=1 for exactly this cycle, then go to BUSY.
  - BUSY: on rd_done, clear full_map[rd_baddr] and go to IDLE.
  - rd_done outside BUSY is ignored.
- Latency: if wr_eop is in cycle k, FSM idle, queue empty and rd_rdy=1, then full_map is set in k+1 and rd_start is high in cycle k+2.
- Back-to-back: rd_done in cycle j with the queue non-empty gives the next rd_start in cycle j+2.
- Simultaneous wr_eop to region r and rd_done releasing the same region r: the release takes effect first, so the write is accepted (full set, queued) with no overflow.
- rd_rdy low holds the FSM in IDLE; queued regions stay full.

Optional Feature:
- HS_PRIORITY_EN defined:
  - Region 0 writes set a separate hs_pend flag and are not pushed to the queue.
  - IDLE serves hs_pend before queue entries; hs_pend clears when its rd_done arrives.
- HS_PRIORITY_EN undefined: region 0 is queued like any data region, in strict completion order.

Test Plan:
- Reset, then wr_eop baddr=1 in cycle 10 with rd_rdy=1 → full_map=4'b0010 in cycle 11, rd_start in cycle 12 with rd_baddr=1; rd_done in cycle 20 → full_map=0 in cycle 21; free_baddr=2.
- rd_rdy=0; writes to baddr 1, 2, 3; then rd_rdy=1 → rd_start sequence 1, 2, 3, each after the prior rd_done. free_vd=0 and acq_throttle=1 while region 1 is full and last_data=3.
- Overflow: write baddr=2 twice without a read → ovf_cnt=1, full_map[2]=1, exactly one rd_start for region 2. Force ovf_cnt to 16'hFFFF, then overflow again → it stays 16'hFFFF.
- Simultaneous rd_done of region 1 and wr_eop baddr=1 → ovf_cnt unchanged, full_map[1]=1, region 1 re-queued.
- HS_PRIORITY_EN: queue holds 2, 3; during BUSY on region 2, wr_eop baddr=0 → next rd_baddr=0, then 3. Without the macro → order 3, then 0.
- Assert rst_n=0 while BUSY → all outputs return to reset values immediately. A later rd_done is ignored, and ovf_cnt stays 0.
